serial_deshiftreg: RTL and testbench
====================================

# serial_deshiftreg

Serial-to-parallel receive shift register with bit counter, word-complete holding register and valid/ready output handshake. Samples `sdata_in` on each `sample_in` strobe, assembles WIDTH-bit words in the configured bit order, and presents each finished word on `pdata_out` until a downstream consumer accepts it. It is the receive-side counterpart to the team's parallel-to-serial `shiftreg`; both share bit-order conventions, so a word serialized with a given LEFT setting is reassembled correctly with the same LEFT setting.

## Interface
- WIDTH, 8: data word width in bits; minimum 2.
- LEFT, 0: bit order; 0 = LSB first (new bit enters at MSB, shifts right); 1 = MSB first (new bit enters at LSB, shifts left).
- Localparam CW = ceil(log2(WIDTH+2)): counter width.
- clock_in  input  1  positive edge-triggered system clock.
- n_reset_in  input  1  reset, synchronous and active-low.
- clear_in  input  1  synchronous abort: drop partial word, empty holding register, clear flags.
- sample_in  input  1  strobe: capture `sdata_in` this cycle.
- sdata_in  input  1  serial data bit.
- ready_in  input  1  consumer accepts `pdata_out` when high with `valid_out`.
- pdata_out  output  WIDTH  last completed word (held).
- valid_out  output  1  `pdata_out` holds an unaccepted word.
- busy_out  output  1  partial word in progress (count_out != 0).
- count_out  output  CW  bits received in current word.
- overrun_out  output  1  sticky: a word completed while the holding register was full and not being drained.
- parity_err_out  output  1  parity mismatch on the current `pdata_out` word (parity build only; tied 0 otherwise).

## Operation
- Internal shift register `sreg` (WIDTH bits) and counter `cnt`; FRAME = WIDTH, or WIDTH+1 with parity.
- Priority per clock edge: reset > clear_in > sample_in/ready_in.
- sample_in: LEFT=0 sreg <= {sdata_in, sreg[WIDTH-1:1]}; LEFT=1 sreg <= {sreg[WIDTH-2:0], sdata_in}; cnt <= cnt+1. With parity, the final (parity) sample is not shifted into sreg.
- Word completion: sample_in while cnt == FRAME-1: cnt <= 0; word = shifted sreg value (data bits only).
  - Holding empty, or full and ready_in high this cycle: pdata_out <= word, valid_out <= 1 (stays high on back-to-back).
  - Holding full and ready_in low: new word discarded, pdata_out unchanged, overrun_out <= 1.
- Handshake: valid_out & ready_in with no completion this cycle -> valid_out <= 0; pdata_out keeps its value.
- clear_in: cnt <= 0, sreg <= 0, valid_out <= 0, overrun_out <= 0, parity_err_out <= 0; pdata_out unchanged; sample_in that cycle ignored.
- Holding state machine: EMPTY (valid_out=0) -> FULL on completion; FULL -> EMPTY on accept without completion; FULL stays FULL on accept+completion or on completion without accept (overrun).
- cnt never exceeds FRAME-1; no wrap beyond frame.

## Timing
- All outputs registered. Reset values: pdata_out 0, valid_out 0, busy_out 0, count_out 0, overrun_out 0, parity_err_out 0; sreg 0.
- valid_out rises the cycle after the final sample_in edge (latency 1 clock from last bit).
- valid_out falls the cycle after acceptance.
- sample_in may be asserted every cycle; sustained throughput one word per FRAME clocks with ready_in held high.
- Reset or clear_in mid-word discards the partial word with no valid_out pulse.

## Configuration
- SERIAL_DESHIFTREG_PARITY_EN defined: frame is WIDTH data bits plus one even-parity bit; on completion parity_err_out <= (XOR of data bits) ^ parity bit, updated only when pdata_out loads; discarded (overrun) words do not affect it.
- Not defined: frame is WIDTH bits; parity_err_out tied 0; counter logic limited to WIDTH.

## Test plan
- WIDTH=8, LEFT=0, no parity: sample bits 1,0,1,0,0,1,0,1 on consecutive cycles -> pdata_out=0xA5, valid_out=1 one cycle after eighth strobe, count_out back to 0.
- LEFT=1: sample 0,0,1,1,1,1,0,0 -> pdata_out=0x3C; ready_in pulse -> valid_out=0 next cycle, pdata_out still 0x3C.
- ready_in held low, receive 0x11 then 0x22 -> pdata_out stays 0x11, overrun_out=1; clear_in -> overrun_out=0, valid_out=0.
- ready_in held high, continuous strobes, words 0x01,0x02 back-to-back -> valid_out never drops between words, pdata_out 0x01 then 0x02, overrun_out=0.
- clear_in (and separately n_reset_in low) after 5 of 8 bits, then full 0xFF -> no valid_out before 0xFF, pdata_out=0xFF.
- Parity build: 0xA5 with parity bit 0 -> parity_err_out=0; 0xA5 with parity bit 1 -> parity_err_out=1.

Source files
------------

// File: rtl/serial_deshiftreg.sv
// Serial-to-parallel receiver with holding register and valid/ready output.
// Optional even-parity frame bit: define SERIAL_DESHIFTREG_PARITY_EN.
module serial_deshiftreg #(
    parameter int WIDTH = 8,
    parameter bit LEFT  = 1'b0,
    localparam int CW   = $clog2(WIDTH + 2)
) (
    input  logic             clock_in,
    input  logic             n_reset_in,
    input  logic             clear_in,
    input  logic             sample_in,
    input  logic             sdata_in,
    input  logic             ready_in,
    output logic [WIDTH-1:0] pdata_out,
    output logic             valid_out,
    output logic             busy_out,
    output logic [CW-1:0]    count_out,
    output logic             overrun_out,
    output logic             parity_err_out
);

`ifdef SERIAL_DESHIFTREG_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} hold_t;

    hold_t            hold_q;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             complete;
    logic             load;

    always_comb begin
        if (LEFT)
            shifted = {sreg[WIDTH-2:0], sdata_in};
        else
            shifted = {sdata_in, sreg[WIDTH-1:1]};
        complete = sample_in && (cnt == LAST);
        load     = complete && ((hold_q == EMPTY) || ready_in);
`ifdef SERIAL_DESHIFTREG_PARITY_EN
        // final strobe carries the parity bit; data is already in sreg
        word = sreg;
`else
        word = shifted;
`endif
        cnt_nxt = cnt;
        if (sample_in)
            cnt_nxt = complete ? '0 : cnt + 1'b1;
    end

    always_ff @(posedge clock_in) begin
        if (!n_reset_in) begin
            sreg        <= '0;
            cnt         <= '0;
            hold_q      <= EMPTY;
            pdata_out   <= '0;
            busy_out    <= 1'b0;
            overrun_out <= 1'b0;
        end else if (clear_in) begin
            sreg        <= '0;
            cnt         <= '0;
            hold_q      <= EMPTY;
            busy_out    <= 1'b0;
            overrun_out <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            busy_out <= (cnt_nxt != '0);
`ifdef SERIAL_DESHIFTREG_PARITY_EN
            if (sample_in && !complete)
                sreg <= shifted;
`else
            if (sample_in)
                sreg <= shifted;
`endif
            if (load) begin
                pdata_out <= word;
                hold_q    <= FULL;
            end else if (complete) begin
                overrun_out <= 1'b1;
            end else if ((hold_q == FULL) && ready_in) begin
                hold_q <= EMPTY;
            end
        end
    end

`ifdef SERIAL_DESHIFTREG_PARITY_EN
    logic parity_q;

    always_ff @(posedge clock_in) begin
        if (!n_reset_in)
            parity_q <= 1'b0;
        else if (clear_in)
            parity_q <= 1'b0;
        else if (load)
            parity_q <= (^sreg) ^ sdata_in;
    end

    assign parity_err_out = parity_q;
`else
    assign parity_err_out = 1'b0;
`endif

    assign valid_out = (hold_q == FULL);
    assign count_out = cnt;

endmodule

// File: tb/tb_serial_deshiftreg.sv
// Directed bench for serial_deshiftreg: LSB-first table, MSB-first
// sequence, and the parity frame when SERIAL_DESHIFTREG_PARITY_EN is set.
module tb_serial_deshiftreg;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       smp;
    logic       sd;
    logic       rdy;

    logic [7:0] pd0;
    logic       v0;
    logic       b0;
    logic [3:0] c0;
    logic       o0;
    logic       pe0;

    logic [7:0] pd1;
    logic       v1;
    logic       b1;
    logic [3:0] c1;
    logic       o1;
    logic       pe1;

    int nvec;
    int nerr;

    typedef struct {
        logic       rst_n;
        logic       clr;
        logic       smp;
        logic       sd;
        logic       rdy;
        logic [7:0] pd;
        logic       v;
        logic [3:0] cnt;
        logic       ovr;
    } vec_t;

    vec_t tbl[$];

    serial_deshiftreg #(.WIDTH(8), .LEFT(1'b0)) u0 (
        .clock_in(clk), .n_reset_in(rst_n), .clear_in(clr),
        .sample_in(smp), .sdata_in(sd), .ready_in(rdy),
        .pdata_out(pd0), .valid_out(v0), .busy_out(b0),
        .count_out(c0), .overrun_out(o0), .parity_err_out(pe0)
    );

    serial_deshiftreg #(.WIDTH(8), .LEFT(1'b1)) u1 (
        .clock_in(clk), .n_reset_in(rst_n), .clear_in(clr),
        .sample_in(smp), .sdata_in(sd), .ready_in(rdy),
        .pdata_out(pd1), .valid_out(v1), .busy_out(b1),
        .count_out(c1), .overrun_out(o1), .parity_err_out(pe1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic c, input logic s,
                        input logic d, input logic y);
        @(negedge clk);
        rst_n = r;
        clr   = c;
        smp   = s;
        sd    = d;
        rdy   = y;
        @(posedge clk);
        #1;
    endtask

    task automatic chk0(input string nm, input logic [7:0] pd,
                        input logic v, input logic [3:0] cnt,
                        input logic ovr, input logic pe);
        nvec++;
        if (pd0 !== pd || v0 !== v || c0 !== cnt || o0 !== ovr ||
            b0 !== (cnt != 4'd0) || pe0 !== pe) begin
            nerr++;
            $display("FAIL %s: got pd=%h v=%b cnt=%0d ovr=%b busy=%b pe=%b want pd=%h v=%b cnt=%0d ovr=%b busy=%b pe=%b",
                     nm, pd0, v0, c0, o0, b0, pe0,
                     pd, v, cnt, ovr, (cnt != 4'd0), pe);
        end
    endtask

    task automatic chk1(input string nm, input logic [7:0] pd,
                        input logic v, input logic [3:0] cnt);
        nvec++;
        if (pd1 !== pd || v1 !== v || c1 !== cnt ||
            b1 !== (cnt != 4'd0)) begin
            nerr++;
            $display("FAIL %s: got pd=%h v=%b cnt=%0d busy=%b want pd=%h v=%b cnt=%0d",
                     nm, pd1, v1, c1, b1, pd, v, cnt);
        end
    endtask

    task automatic vec(input logic r, input logic c, input logic s,
                       input logic d, input logic y, input logic [7:0] pd,
                       input logic v, input logic [3:0] cnt,
                       input logic ovr);
        vec_t e;
        e.rst_n = r;
        e.clr   = c;
        e.smp   = s;
        e.sd    = d;
        e.rdy   = y;
        e.pd    = pd;
        e.v     = v;
        e.cnt   = cnt;
        e.ovr   = ovr;
        tbl.push_back(e);
    endtask

    // eight LSB-first strobes; ready only on the final one
    task automatic word(input logic [7:0] w, input logic rl,
                        input logic [7:0] pdd, input logic vd,
                        input logic od, input logic [7:0] pde,
                        input logic ve, input logic oe);
        for (int i = 0; i < 8; i++) begin
            if (i < 7)
                vec(1, 0, 1, w[i], 0, pdd, vd, 4'(i + 1), od);
            else
                vec(1, 0, 1, w[i], rl, pde, ve, 4'd0, oe);
        end
    endtask

    task automatic partial(input int n, input logic [7:0] pd);
        for (int i = 0; i < n; i++)
            vec(1, 0, 1, 1, 0, pd, 0, 4'(i + 1), 0);
    endtask

    initial begin
        nvec  = 0;
        nerr  = 0;
        rst_n = 1'b0;
        clr   = 1'b0;
        smp   = 1'b0;
        sd    = 1'b0;
        rdy   = 1'b0;

`ifdef SERIAL_DESHIFTREG_PARITY_EN
        begin
            logic [8:0] f0;
            logic [8:0] f1;
            f0 = {1'b0, 8'hA5};
            f1 = {1'b1, 8'hA5};
            step(0, 0, 0, 0, 0);
            chk0("p_reset", 8'h00, 0, 0, 0, 0);
            for (int i = 0; i < 9; i++) begin
                step(1, 0, 1, f0[i], 0);
                if (i == 7)
                    chk0("p_eight", 8'h00, 0, 8, 0, 0);
            end
            chk0("p_good", 8'hA5, 1, 0, 0, 0);
            step(1, 0, 0, 0, 1);
            chk0("p_accept", 8'hA5, 0, 0, 0, 0);
            for (int i = 0; i < 9; i++)
                step(1, 0, 1, f1[i], 0);
            chk0("p_bad", 8'hA5, 1, 0, 0, 1);
            step(1, 1, 0, 0, 0);
            chk0("p_clear", 8'hA5, 0, 0, 0, 0);
        end
`else
        vec(0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        vec(0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        vec(1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        word(8'hA5, 0, 8'h00, 0, 0, 8'hA5, 1, 0);
        vec(1, 0, 0, 0, 1, 8'hA5, 0, 0, 0);
        vec(1, 0, 0, 0, 0, 8'hA5, 0, 0, 0);
        word(8'h11, 0, 8'hA5, 0, 0, 8'h11, 1, 0);
        word(8'h22, 0, 8'h11, 1, 0, 8'h11, 1, 1);
        vec(1, 0, 0, 0, 0, 8'h11, 1, 0, 1);
        vec(1, 1, 1, 1, 0, 8'h11, 0, 0, 0);
        word(8'h01, 0, 8'h11, 0, 0, 8'h01, 1, 0);
        word(8'h02, 1, 8'h01, 1, 0, 8'h02, 1, 0);
        vec(1, 0, 0, 0, 1, 8'h02, 0, 0, 0);
        partial(5, 8'h02);
        vec(1, 1, 1, 1, 0, 8'h02, 0, 0, 0);
        word(8'hFF, 0, 8'h02, 0, 0, 8'hFF, 1, 0);
        vec(1, 0, 0, 0, 1, 8'hFF, 0, 0, 0);
        partial(5, 8'hFF);
        vec(1, 0, 0, 1, 0, 8'hFF, 0, 5, 0);
        vec(0, 0, 1, 1, 0, 8'h00, 0, 0, 0);
        word(8'hFF, 0, 8'h00, 0, 0, 8'hFF, 1, 0);

        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].rst_n, tbl[k].clr, tbl[k].smp, tbl[k].sd, tbl[k].rdy);
            chk0($sformatf("row%0d", k), tbl[k].pd, tbl[k].v,
                 tbl[k].cnt, tbl[k].ovr, 1'b0);
        end

        begin
            logic [7:0] m;
            m = 8'h3C;
            step(0, 0, 0, 0, 0);
            chk1("msb_reset", 8'h00, 0, 0);
            for (int i = 7; i >= 0; i--) begin
                step(1, 0, 1, m[i], 0);
                if (i == 4)
                    chk1("msb_half", 8'h00, 0, 4);
            end
            chk1("msb_word", 8'h3C, 1, 0);
            step(1, 0, 0, 0, 1);
            chk1("msb_accept", 8'h3C, 0, 0);
            step(1, 0, 0, 0, 0);
            chk1("msb_hold", 8'h3C, 0, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
